uart_rx_buffer: RTL and testbench

Receive-side byte buffer that sits directly downstream of the `uart` transceiver. It consumes each received byte via the uart's `ready` / `ready_clr` handshake and stores it in a first-word-fall-through FIFO. It then presents the bytes to the consumer (LED/display logic or a command parser) on a valid/ready stream. Capture is decoupled from consumption, so the uart never stalls and bytes are not lost while the consumer is busy; overflow is detected and flagged.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_rx_buffer.sv | 132 +++++++++++++
 tb/tb_uart_rx_buffer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the uart receive path.
//   UART_DATA_W : byte width carried between uart and buffer
//   cap_state_e : capture FSM state encoding (IDLE, CLR)
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    CLR  = 1'b1
  } cap_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO (storage, pointers, level).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push_i      : write wr_data_i (ignored when full unless popping too)
//   pop_i       : advance the head (ignored when empty)
//   wr_data_i   : write data
//   rd_data_o   : head entry, combinational
//   level_o     : entry count, 0..DEPTH
//   full_o      : DEPTH entries stored
//   empty_o     : no entries stored
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the push needs, so full only blocks a lone push.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: captures bytes from the uart ready/ready_clr handshake
// into a FWFT FIFO and presents them on a valid/ready stream.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   rx_data       : received byte, valid while rx_ready is high
//   rx_ready      : uart ready level
//   rx_ready_clr  : registered clear back to the uart
//   out_data      : FIFO head (meaningful while out_valid)
//   out_valid     : FIFO not empty
//   out_ready     : consumer accepts the head
//   level         : entry count
//   overflow      : sticky dropped-byte flag, cleared by ovf_clr
//   ovf_clr       : clears overflow (and drop_cnt)
//   drop_cnt      : saturating dropped-byte count
// Build option: UART_RX_BUF_DROP_CNT_EN enables the drop counter;
// otherwise drop_cnt is constant zero.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = UART_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   rx_ready,
  output logic                   rx_ready_clr,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic [7:0]             drop_cnt
);

  cap_state_e state_q;
  logic       rx_ready_clr_q;
  logic       overflow_q, overflow_d;
  logic       fifo_full, fifo_empty;
  logic       pop_fire, capture, push, drop;

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (out_ready),
    .wr_data_i (rx_data),
    .rd_data_o (out_data),
    .level_o   (level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop_fire  = out_valid && out_ready;

  // One capture per rx_ready assertion: only IDLE samples the byte.
  assign capture = (state_q == IDLE) && rx_ready;
  assign push    = capture && (!fifo_full || pop_fire);
  assign drop    = capture && fifo_full && !pop_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rx_ready_clr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_ready) begin
            rx_ready_clr_q <= 1'b1;
            state_q        <= CLR;
          end
        end
        CLR: begin
          if (!rx_ready) begin
            rx_ready_clr_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: begin
          rx_ready_clr_q <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  assign rx_ready_clr = rx_ready_clr_q;

  // Set has priority over clear.
  always_comb begin
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

`ifdef UART_RX_BUF_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // A drop coinciding with ovf_clr restarts the count at 1.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (ovf_clr)                 drop_cnt_d = 8'd1;
      else if (drop_cnt_q != '1)   drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: self-checking bench for uart_rx_buffer.
// A negedge monitor compares every accepted output byte with a queue of
// bytes the stimulus expects to have been captured.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_ready_clr;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;
  logic       overflow;
  logic       ovf_clr;
  logic [7:0] drop_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;
  int         max_level = 0;

`ifdef UART_RX_BUF_DROP_CNT_EN
  localparam logic [7:0] EXP_DROP1 = 8'd1;
`else
  localparam logic [7:0] EXP_DROP1 = 8'd0;
`endif

  uart_rx_buffer #(.DEPTH(16), .DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_ready_clr (rx_ready_clr),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  // Consumer side scoreboard: a byte leaves the FIFO on the next posedge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (int'(level) > max_level) max_level = int'(level);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got %02h, required no output", out_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_data: got %02h, required %02h", out_data, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // uart model: hold ready until clr seen, release one cycle later.
  task automatic send_byte(input logic [7:0] b, input bit accept);
    int n;
    rx_data  = b;
    rx_ready = 1'b1;
    if (accept) exp_q.push_back(b);
    n = 0;
    do begin tick(); n++; end while (!rx_ready_clr && n < 8);
    if (!rx_ready_clr) begin
      checks++; errors++;
      $display("FAIL clr_rise_timeout: got 0, required 1");
    end
    tick();
    rx_ready = 1'b0;
    n = 0;
    do begin tick(); n++; end while (rx_ready_clr && n < 8);
    if (rx_ready_clr) begin
      checks++; errors++;
      $display("FAIL clr_fall_timeout: got 1, required 0");
    end
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d left, required 0", exp_q.size());
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got out_valid %b, required 0", out_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0 || rx_ready_clr !== 1'b0 ||
        overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset: got lvl %0d v %b clr %b ovf %b dc %0d, required 0 0 0 0 0",
               level, out_valid, rx_ready_clr, overflow, drop_cnt);
    end
  endtask

  task automatic test_single_byte();
    do_reset();
    rx_data  = 8'h01;
    rx_ready = 1'b1;
    exp_q.push_back(8'h01);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01 || level !== 5'd1 || rx_ready_clr !== 1'b1) begin
      errors++;
      $display("FAIL single_first: got v %b d %02h lvl %0d clr %b, required 1 01 1 1",
               out_valid, out_data, level, rx_ready_clr);
    end
    repeat (4) tick();
    checks++;
    if (level !== 5'd1 || rx_ready_clr !== 1'b1) begin
      errors++;
      $display("FAIL single_hold: got lvl %0d clr %b, required 1 1", level, rx_ready_clr);
    end
    rx_ready = 1'b0;
    tick();
    checks++;
    if (rx_ready_clr !== 1'b0 || level !== 5'd1) begin
      errors++;
      $display("FAIL single_clr_fall: got clr %b lvl %0d, required 0 1", rx_ready_clr, level);
    end
    drain();
  endtask

  task automatic test_loopback();
    do_reset();
    out_ready = 1'b1;
    for (int b = 1; b <= 255; b++) begin
      send_byte(8'(b), 1'b1);
      if (b % 3 == 0) tick();
    end
    drain();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL loopback_ovf: got %b, required 0", overflow);
    end
  endtask

  task automatic test_fill_and_full_simul();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b1);
    checks++;
    if (level !== 5'd16) begin
      errors++;
      $display("FAIL fill_level: got %0d, required 16", level);
    end
    send_byte(8'hAA, 1'b0);
    checks++;
    if (overflow !== 1'b1 || drop_cnt !== EXP_DROP1 || out_data !== 8'h10 || level !== 5'd16) begin
      errors++;
      $display("FAIL fill_drop: got ovf %b dc %0d head %02h lvl %0d, required 1 %0d 10 16",
               overflow, drop_cnt, out_data, level, EXP_DROP1);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL ovf_clr: got ovf %b dc %0d, required 0 0", overflow, drop_cnt);
    end
    // Capture at full with a pop in the same cycle.
    rx_data   = 8'hBB;
    rx_ready  = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(8'hBB);
    tick();
    out_ready = 1'b0;
    checks++;
    if (level !== 5'd16 || overflow !== 1'b0 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL full_simul: got lvl %0d ovf %b head %02h, required 16 0 11",
               level, overflow, out_data);
    end
    tick();
    rx_ready = 1'b0;
    tick();
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    max_level = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) out_ready = 1'b1;
      send_byte(8'(i * 7 + 3), 1'b1);
    end
    drain();
    checks++;
    if (max_level > 16 || max_level < 10) begin
      errors++;
      $display("FAIL wrap_level: got max %0d, required 10..16", max_level);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 1'b1);
    send_byte(8'hAA, 1'b0);
    rx_data  = 8'h5A;
    rx_ready = 1'b1;
    tick();
    checks++;
    if (rx_ready_clr !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got clr %b ovf %b, required 1 1", rx_ready_clr, overflow);
    end
    rst = 1'b1;
    exp_q.delete();
    tick();
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0 || rx_ready_clr !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got lvl %0d v %b clr %b ovf %b, required 0 0 0 0",
               level, out_valid, rx_ready_clr, overflow);
    end
    // rx_ready still high after reset: captured as a fresh byte.
    rst     = 1'b0;
    rx_data = 8'h66;
    exp_q.push_back(8'h66);
    tick();
    checks++;
    if (level !== 5'd1 || out_data !== 8'h66 || rx_ready_clr !== 1'b1) begin
      errors++;
      $display("FAIL mid_recapture: got lvl %0d d %02h clr %b, required 1 66 1",
               level, out_data, rx_ready_clr);
    end
    rx_ready = 1'b0;
    tick();
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    rx_data   = '0;
    rx_ready  = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    mon_en    = 1'b1;
    test_reset();
    test_single_byte();
    test_loopback();
    test_fill_and_full_simul();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
